// File: rtl/router_port_fifo.sv
// Per-channel output FIFO behind the router core: first-word fall-through reads,
// almost-full back-pressure, sticky overflow and a stall-timeout flush.
module router_port_fifo #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic [7:0]        dout,
  output logic              vld_out,
  input  logic              read_enb,
  output logic              suspend,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              timeout_flush
);

  localparam int STALL_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W:0]    FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]    SUSP_CNT  = (ADDR_W+1)'(DEPTH - 2);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT - 1);

  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                overflow_q, overflow_d;
  logic                flush_q, flush_d;

  logic pop, push, drop, stalled, flush;

  assign vld_out       = (count_q != '0);
  assign suspend       = (count_q >= SUSP_CNT);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign timeout_flush = flush_q;
  assign dout          = vld_out ? mem[rd_ptr_q] : 8'h00;

  always_comb begin
    pop     = read_enb && vld_out;
    stalled = vld_out && !read_enb;
    flush   = stalled && (stall_q == STALL_MAX);
    // A flush edge swallows any incoming byte without counting it as a drop.
    push    = din_valid && !flush && ((count_q != FULL_CNT) || pop);
    drop    = din_valid && !flush && (count_q == FULL_CNT) && !pop;

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    stall_d    = '0;
    overflow_d = overflow_q || drop;
    flush_d    = flush;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (stalled) stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= '0;
      overflow_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      flush_q    <= flush_d;
    end
  end

  // Storage needs no reset: dout is gated by vld_out.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_router_port_fifo.sv
// Directed bench for router_port_fifo: a vector table for basic push/pop plus
// hand-written sequences for full, wrap, timeout, streaming and async reset.
module tb_router_port_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] dout;
  logic       vld_out;
  logic       read_enb;
  logic       suspend;
  logic [4:0] count;
  logic       overflow;
  logic       timeout_flush;

  int checks = 0;
  int errors = 0;

  router_port_fifo #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(30)) dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout), .vld_out(vld_out), .read_enb(read_enb), .suspend(suspend),
    .count(count), .overflow(overflow), .timeout_flush(timeout_flush)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       dv;
    logic [7:0] d;
    logic       re;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] ec;
    logic       es;
    logic       eo;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic dv, input logic [7:0] d, input logic re);
    din_valid = dv;
    din       = d;
    read_enb  = re;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    din       = 8'h00;
    read_enb  = 1'b0;
    reset     = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(base + i), 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    din_valid = 1'b0;
    din = 8'h00;
    read_enb = 1'b0;
    #2;
    check("reset_vld", {7'b0, vld_out}, 8'h00);
    check("reset_dout", dout, 8'h00);
    check("reset_count", {3'b0, count}, 8'h00);
    check("reset_flush", {7'b0, timeout_flush}, 8'h00);
    do_reset();

    // Basic push of three bytes then three pops.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 5'd2, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h7E, 1'b0, 1'b1, 8'hA5, 5'd3, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 5'd2, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h7E, 5'd1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    for (int v = 0; v < 7; v++) begin
      step(tbl[v].dv, tbl[v].d, tbl[v].re);
      $display("vec %0d: dv=%0b din=%02h re=%0b -> vld=%0b dout=%02h count=%0d",
               v, tbl[v].dv, tbl[v].d, tbl[v].re, vld_out, dout, count);
      check("tbl_vld", {7'b0, vld_out}, {7'b0, tbl[v].ev});
      check("tbl_dout", dout, tbl[v].ed);
      check("tbl_count", {3'b0, count}, {3'b0, tbl[v].ec});
      check("tbl_suspend", {7'b0, suspend}, {7'b0, tbl[v].es});
      check("tbl_overflow", {7'b0, overflow}, {7'b0, tbl[v].eo});
    end

    // Fill, overflow drop, drain with suspend thresholds.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      check("fill_count", {3'b0, count}, 8'(i + 1));
      check("fill_suspend", {7'b0, suspend}, {7'b0, (i + 1) >= 14});
    end
    check("fill_no_ovf", {7'b0, overflow}, 8'h00);
    step(1'b1, 8'hFF, 1'b0);
    check("drop_count", {3'b0, count}, 8'd16);
    check("drop_ovf", {7'b0, overflow}, 8'h01);
    check("drop_dout", dout, 8'h00);
    for (int i = 0; i < 16; i++) begin
      check("drain_dout", dout, 8'(i));
      step(1'b0, 8'h00, 1'b1);
      check("drain_suspend", {7'b0, suspend}, {7'b0, (15 - i) >= 14});
    end
    check("drain_vld", {7'b0, vld_out}, 8'h00);
    check("drain_dout0", dout, 8'h00);
    check("drain_ovf_sticky", {7'b0, overflow}, 8'h01);

    // Push and pop together while full; pointers wrap.
    do_reset();
    check("rst_clears_ovf", {7'b0, overflow}, 8'h00);
    fill16(8'h10);
    step(1'b1, 8'h55, 1'b1);
    check("full_pp_count", {3'b0, count}, 8'd16);
    check("full_pp_ovf", {7'b0, overflow}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      check("wrap_dout", dout, (i < 15) ? 8'(8'h11 + i) : 8'h55);
      step(1'b0, 8'h00, 1'b1);
    end
    check("wrap_empty", {3'b0, count}, 8'h00);

    // Timeout: flush on the 30th edge after vld_out rises; push in flush cycle dropped.
    do_reset();
    step(1'b1, 8'h11, 1'b0);
    for (int k = 1; k < 30; k++) begin
      step(1'b0, 8'h00, 1'b0);
      check("to_no_flush", {7'b0, timeout_flush}, 8'h00);
    end
    check("to_still_vld", {7'b0, vld_out}, 8'h01);
    step(1'b1, 8'h99, 1'b0);
    check("to_flush", {7'b0, timeout_flush}, 8'h01);
    check("to_vld", {7'b0, vld_out}, 8'h00);
    check("to_count", {3'b0, count}, 8'h00);
    check("to_dout", dout, 8'h00);
    check("to_no_ovf", {7'b0, overflow}, 8'h00);
    step(1'b0, 8'h00, 1'b0);
    check("to_pulse_end", {7'b0, timeout_flush}, 8'h00);
    check("to_count_after", {3'b0, count}, 8'h00);

    // Pop at edge 29 restarts the stall count.
    do_reset();
    step(1'b1, 8'h11, 1'b0);
    for (int k = 1; k < 29; k++) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h22, 1'b1);
    check("rs_no_flush", {7'b0, timeout_flush}, 8'h00);
    check("rs_dout", dout, 8'h22);
    check("rs_count", {3'b0, count}, 8'h01);
    for (int k = 1; k < 30; k++) begin
      step(1'b0, 8'h00, 1'b0);
      check("rs_hold", {7'b0, timeout_flush}, 8'h00);
    end
    check("rs_vld", {7'b0, vld_out}, 8'h01);
    step(1'b0, 8'h00, 1'b0);
    check("rs_flush", {7'b0, timeout_flush}, 8'h01);

    // Streaming: push and pop every cycle.
    do_reset();
    step(1'b1, 8'h00, 1'b1);
    check("st_first_vld", {7'b0, vld_out}, 8'h01);
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 8'(i), 1'b1);
      check("st_dout", dout, 8'(i));
      check("st_count", {3'b0, count}, 8'h01);
    end

    // Asynchronous reset mid-stream at count 9 with overflow set.
    do_reset();
    fill16(8'h00);
    step(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    din_valid = 1'b0;
    read_enb  = 1'b0;
    check("pre_count", {3'b0, count}, 8'd9);
    check("pre_ovf", {7'b0, overflow}, 8'h01);
    #3;
    reset = 1'b1;
    #1;
    check("ar_vld", {7'b0, vld_out}, 8'h00);
    check("ar_dout", dout, 8'h00);
    check("ar_count", {3'b0, count}, 8'h00);
    check("ar_suspend", {7'b0, suspend}, 8'h00);
    check("ar_ovf", {7'b0, overflow}, 8'h00);
    check("ar_flush", {7'b0, timeout_flush}, 8'h00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1'b1, 8'h42, 1'b0);
    check("post_dout", dout, 8'h42);
    check("post_count", {3'b0, count}, 8'h01);
    step(1'b0, 8'h00, 1'b1);
    check("post_empty", {7'b0, vld_out}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
